stage_sequencer: RTL and testbench

STAGE_SEQUENCER -- requirements
Module: stage_sequencer

---
 rtl/stage_sequencer.sv | 128 ++++++++++++
 tb/tb_stage_sequencer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/stage_sequencer.sv
// Four-stage instruction sequencer with blanked ready handshakes.
// Optional stage timeout / FAULT state enabled by STAGE_TIMEOUT_EN.
module stage_sequencer #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             halt_req,
  input  logic             fetch_ready,
  input  logic             decode_ready,
  input  logic             exec_ready,
  input  logic             wb_ready,
  input  logic [1:0]       op,
  output logic             fetch_en,
  output logic             decode_en,
  output logic             exec_en,
  output logic             wb_en,
  output logic             busy,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] instr_count
);

`ifdef STAGE_TIMEOUT_EN
  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, EXEC, WB, HALT, FAULT
  } state_t;
  localparam logic [7:0] TLIM = 8'(TIMEOUT - 1);
  logic [7:0] tcnt;
`else
  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, EXEC, WB, HALT
  } state_t;
`endif

  state_t state, nxt;
  logic   first;
  logic   pend;
  logic   stage;
  logic   rdy;
  logic   q;
  logic   retire;
  logic   unused_op;

  assign unused_op = op[1];

  always_comb begin
    nxt    = state;
    retire = 1'b0;
    stage  = (state == FETCH) || (state == DECODE) ||
             (state == EXEC)  || (state == WB);
    rdy    = 1'b0;
    unique case (1'b1)
      (state == FETCH):  rdy = fetch_ready;
      (state == DECODE): rdy = decode_ready;
      (state == EXEC):   rdy = exec_ready;
      (state == WB):     rdy = wb_ready;
      default:           rdy = 1'b0;
    endcase
    // first cycle of every stage discards ready
    q = rdy && !first;
    case (state)
      IDLE:   if (run) nxt = FETCH;
      FETCH:  if (q) nxt = DECODE;
      DECODE: if (q) nxt = EXEC;
      EXEC: begin
        if (q) begin
          if (op[0]) nxt = WB;
          else       retire = 1'b1;
        end
      end
      WB:     if (q) retire = 1'b1;
      HALT:   if (!run) nxt = IDLE;
      default: nxt = state;
    endcase
    if (retire) begin
      if (halt_req || pend) nxt = HALT;
      else if (run)         nxt = FETCH;
      else                  nxt = IDLE;
    end
`ifdef STAGE_TIMEOUT_EN
    if (stage && !q && tcnt == TLIM) nxt = FAULT;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      first       <= 1'b0;
      pend        <= 1'b0;
      fetch_en    <= 1'b0;
      decode_en   <= 1'b0;
      exec_en     <= 1'b0;
      wb_en       <= 1'b0;
      busy        <= 1'b0;
      halted      <= 1'b0;
      instr_count <= '0;
`ifdef STAGE_TIMEOUT_EN
      fault       <= 1'b0;
      tcnt        <= '0;
`endif
    end else begin
      state     <= nxt;
      first     <= (nxt != state);
      fetch_en  <= (nxt == FETCH);
      decode_en <= (nxt == DECODE);
      exec_en   <= (nxt == EXEC);
      wb_en     <= (nxt == WB);
      busy      <= (nxt != IDLE) && (nxt != HALT);
      halted    <= (nxt == HALT);
      if (retire) instr_count <= instr_count + 1'b1;
      if (nxt == HALT)           pend <= 1'b0;
      else if (stage && halt_req) pend <= 1'b1;
`ifdef STAGE_TIMEOUT_EN
      fault <= (nxt == FAULT);
      if (nxt != state) tcnt <= '0;
      else if (stage)   tcnt <= tcnt + 8'd1;
`endif
    end
  end

`ifndef STAGE_TIMEOUT_EN
  assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed bench for stage_sequencer (CNT_W=4, TIMEOUT=4).
// Timeout checks run only when STAGE_TIMEOUT_EN is defined.
module tb_stage_sequencer;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       run, halt_req;
  logic       fetch_ready, decode_ready, exec_ready, wb_ready;
  logic [1:0] op;
  logic       fetch_en, decode_en, exec_en, wb_en;
  logic       busy, halted, fault;
  logic [3:0] instr_count;

  int checks = 0;
  int errors = 0;

  stage_sequencer #(.TIMEOUT(4), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .halt_req(halt_req),
    .fetch_ready(fetch_ready), .decode_ready(decode_ready),
    .exec_ready(exec_ready), .wb_ready(wb_ready), .op(op),
    .fetch_en(fetch_en), .decode_en(decode_en),
    .exec_en(exec_en), .wb_en(wb_en), .busy(busy),
    .halted(halted), .fault(fault), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_en(string tag, logic [3:0] exp);
    chk(tag, {28'd0, fetch_en, decode_en, exec_en, wb_en}, {28'd0, exp});
  endtask

  // blanking cycle, then one cycle of ready for stage s
  task automatic complete(int s);
    step();
    case (s)
      0: fetch_ready = 1'b1;
      1: decode_ready = 1'b1;
      2: exec_ready = 1'b1;
      default: wb_ready = 1'b1;
    endcase
    step();
    fetch_ready = 1'b0; decode_ready = 1'b0;
    exec_ready = 1'b0;  wb_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; halt_req = 1'b0; op = 2'b01;
    fetch_ready = 1'b0; decode_ready = 1'b0;
    exec_ready = 1'b0;  wb_ready = 1'b0;
    #12;
    chk_en("reset_en", 4'b0000);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_halted", {31'd0, halted}, 32'd0);
    chk("reset_fault", {31'd0, fault}, 32'd0);
    chk("reset_cnt", {28'd0, instr_count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // op=01 full four-stage instruction
    run = 1'b1;
    step();
    chk_en("t1_fetch", 4'b1000);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    step();
    chk_en("t1_fetch_blank", 4'b1000);
    fetch_ready = 1'b1;
    step();
    fetch_ready = 1'b0;
    chk_en("t1_decode", 4'b0100);
    complete(1);
    chk_en("t1_exec", 4'b0010);
    complete(2);
    chk_en("t1_wb", 4'b0001);
    chk("t1_cnt_pre", {28'd0, instr_count}, 32'd0);
    complete(3);
    chk_en("t1_next_fetch", 4'b1000);
    chk("t1_cnt", {28'd0, instr_count}, 32'd1);

    // op=10 skips WB
    op = 2'b10;
    complete(0);
    chk_en("t2_decode", 4'b0100);
    complete(1);
    chk_en("t2_exec", 4'b0010);
    complete(2);
    chk_en("t2_fetch_nowb", 4'b1000);
    chk("t2_cnt", {28'd0, instr_count}, 32'd2);

    // stale wb_ready at WB entry
    op = 2'b01;
    complete(0);
    complete(1);
    step();
    exec_ready = 1'b1;
    wb_ready = 1'b1;
    step();
    exec_ready = 1'b0;
    chk_en("t3_wb", 4'b0001);
    step();
    chk_en("t3_wb_blank", 4'b0001);
    chk("t3_cnt_hold", {28'd0, instr_count}, 32'd2);
    step();
    wb_ready = 1'b0;
    chk_en("t3_fetch", 4'b1000);
    chk("t3_cnt", {28'd0, instr_count}, 32'd3);

    // halt pulse during DECODE
    complete(0);
    chk_en("t4_decode", 4'b0100);
    halt_req = 1'b1;
    step();
    halt_req = 1'b0;
    decode_ready = 1'b1;
    step();
    decode_ready = 1'b0;
    chk_en("t4_exec", 4'b0010);
    op = 2'b00;
    complete(2);
    chk_en("t4_halt_en", 4'b0000);
    chk("t4_halted", {31'd0, halted}, 32'd1);
    chk("t4_busy", {31'd0, busy}, 32'd0);
    chk("t4_cnt", {28'd0, instr_count}, 32'd4);
    step();
    chk("t4_hold", {31'd0, halted}, 32'd1);
    run = 1'b0;
    step();
    chk("t4_idle_halted", {31'd0, halted}, 32'd0);
    chk("t4_idle_busy", {31'd0, busy}, 32'd0);
    chk_en("t4_idle_en", 4'b0000);

    // counter wrap: 12 more instructions from 4
    run = 1'b1;
    step();
    for (int i = 0; i < 11; i++) begin
      complete(0);
      complete(1);
      complete(2);
    end
    chk("t5_cnt15", {28'd0, instr_count}, 32'd15);
    run = 1'b0;
    complete(0);
    complete(1);
    complete(2);
    chk("t5_wrap", {28'd0, instr_count}, 32'd0);
    chk("t5_idle_busy", {31'd0, busy}, 32'd0);
    chk_en("t5_idle_en", 4'b0000);

    // reset mid-stage
    run = 1'b1;
    step();
    chk_en("t6_fetch", 4'b1000);
    #2;
    rst_n = 1'b0;
    #1;
    chk_en("t6_async_en", 4'b0000);
    chk("t6_async_busy", {31'd0, busy}, 32'd0);
    chk("t6_async_cnt", {28'd0, instr_count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_en("t6_release_idle", 4'b0000);
    step();
    chk_en("t6_restart", 4'b1000);

`ifdef STAGE_TIMEOUT_EN
    op = 2'b01;
    complete(0);
    complete(1);
    chk_en("t7_exec1", 4'b0010);
    step();
    chk_en("t7_exec2", 4'b0010);
    step();
    chk_en("t7_exec3", 4'b0010);
    step();
    chk_en("t7_exec4", 4'b0010);
    chk("t7_nofault", {31'd0, fault}, 32'd0);
    step();
    chk("t7_fault", {31'd0, fault}, 32'd1);
    chk_en("t7_fault_en", 4'b0000);
    step();
    chk("t7_fault_hold", {31'd0, fault}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t7_reset_fault", {31'd0, fault}, 32'd0);
    chk_en("t7_reset_en", 4'b0000);
`else
    chk("t7_fault_tied", {31'd0, fault}, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
